// File: rtl/hdr_chk_pkg.sv
// Shared constants for the OFC1 header consistency checker.
package hdr_chk_pkg;

    // Default geometry of the checker.
    localparam int unsigned DEF_N_CH      = 4;
    localparam int unsigned DEF_EVTNO_W   = 16;
    localparam int unsigned DEF_SPILLNO_W = 10;
    localparam int unsigned DEF_ERRCNT_W  = 8;
    localparam int unsigned DEF_EVT_START = 1;

    // Per-channel package counter width; also the slice stride of in_counter.
    localparam int unsigned IN_CNT_W      = 16;

    // Error-summary flags carried per channel.
    typedef struct packed {
        logic evtno;
        logic spillno;
    } chk_flags_t;

endpackage : hdr_chk_pkg

// File: rtl/header_checker_ch.sv
// One channel of the header checker: expected event counter, compare,
// error counter, package counter and first-error capture with lock bits.
// Optional HDR_CHK_RESYNC_EN: re-align expected event number on mismatch.
module header_checker_ch
    import hdr_chk_pkg::*;
#(
    parameter int unsigned EVTNO_W   = DEF_EVTNO_W,
    parameter int unsigned SPILLNO_W = DEF_SPILLNO_W,
    parameter int unsigned ERRCNT_W  = DEF_ERRCNT_W,
    parameter int unsigned EVT_START = DEF_EVT_START
) (
    input  logic                 clk,
    input  logic                 live_rising,
    input  logic [SPILLNO_W-1:0] exp_spillno,
    input  logic                 get_package,
    input  logic [EVTNO_W-1:0]   pkg_evtno,
    input  logic [SPILLNO_W-1:0] pkg_spillno,
    output logic                 evtno_err,
    output logic                 spillno_err,
    output logic                 err_sticky,
    output logic [IN_CNT_W-1:0]  in_counter,
    output logic [ERRCNT_W-1:0]  err_count,
    output logic [EVTNO_W-1:0]   r_evtno,
    output logic [EVTNO_W-1:0]   r_expevtno,
    output logic [SPILLNO_W-1:0] r_spillno
);

    logic [EVTNO_W-1:0] exp_evtno;
    logic               evt_lock;
    logic               spill_lock;

    chk_flags_t         mis_c;
    logic               any_mis_c;
    logic               cnt_sat_c;
    logic [EVTNO_W-1:0] exp_next_c;

    // Compare the incoming header and work out the next expected event number.
    always_comb begin
        mis_c.evtno   = (pkg_evtno != exp_evtno);
        mis_c.spillno = (pkg_spillno != exp_spillno);
        any_mis_c     = mis_c.evtno | mis_c.spillno;
        cnt_sat_c     = &err_count;
        exp_next_c    = exp_evtno + EVTNO_W'(1);
`ifdef HDR_CHK_RESYNC_EN
        if (mis_c.evtno) begin
            exp_next_c = pkg_evtno + EVTNO_W'(1);
        end
`endif
    end

    // Expected counter and last-check flags; flags hold between strobes.
    always_ff @(posedge clk) begin
        if (live_rising) begin
            exp_evtno   <= EVTNO_W'(EVT_START);
            evtno_err   <= 1'b0;
            spillno_err <= 1'b0;
            err_sticky  <= 1'b0;
        end else if (get_package) begin
            exp_evtno   <= exp_next_c;
            evtno_err   <= mis_c.evtno;
            spillno_err <= mis_c.spillno;
            err_sticky  <= err_sticky | any_mis_c;
        end
    end

    // Package counter (wrapping) and saturating error counter.
    always_ff @(posedge clk) begin
        if (live_rising) begin
            in_counter <= '0;
            err_count  <= '0;
        end else if (get_package) begin
            in_counter <= in_counter + IN_CNT_W'(1);
            if (any_mis_c && !cnt_sat_c) begin
                err_count <= err_count + ERRCNT_W'(1);
            end
        end
    end

    // First event-number error capture, frozen by its lock bit.
    always_ff @(posedge clk) begin
        if (live_rising) begin
            evt_lock   <= 1'b0;
            r_evtno    <= '0;
            r_expevtno <= '0;
        end else if (get_package && mis_c.evtno && !evt_lock) begin
            evt_lock   <= 1'b1;
            r_evtno    <= pkg_evtno;
            r_expevtno <= exp_evtno;
        end
    end

    // First spill-number error capture, independent lock.
    always_ff @(posedge clk) begin
        if (live_rising) begin
            spill_lock <= 1'b0;
            r_spillno  <= '0;
        end else if (get_package && mis_c.spillno && !spill_lock) begin
            spill_lock <= 1'b1;
            r_spillno  <= pkg_spillno;
        end
    end

endmodule : header_checker_ch

// File: rtl/header_checker_mc.sv
// Multi-channel header consistency checker for the OFC1 receive path.
// Slices the channel buses, instantiates one checker per channel and
// ORs the sticky flags. Optional HDR_CHK_RESYNC_EN is handled per channel.
module header_checker_mc
    import hdr_chk_pkg::*;
#(
    parameter int unsigned N_CH      = DEF_N_CH,
    parameter int unsigned EVTNO_W   = DEF_EVTNO_W,
    parameter int unsigned SPILLNO_W = DEF_SPILLNO_W,
    parameter int unsigned ERRCNT_W  = DEF_ERRCNT_W,
    parameter int unsigned EVT_START = DEF_EVT_START
) (
    input  logic                        clk,
    input  logic                        live_rising,
    input  logic [SPILLNO_W-1:0]        exp_spillno,
    input  logic [N_CH-1:0]             get_package,
    input  logic [N_CH*EVTNO_W-1:0]     pkg_evtno,
    input  logic [N_CH*SPILLNO_W-1:0]   pkg_spillno,
    output logic [N_CH-1:0]             evtno_err,
    output logic [N_CH-1:0]             spillno_err,
    output logic [N_CH-1:0]             err_sticky,
    output logic                        any_err,
    output logic [N_CH*IN_CNT_W-1:0]    in_counter,
    output logic [N_CH*ERRCNT_W-1:0]    err_count,
    output logic [N_CH*EVTNO_W-1:0]     r_evtno,
    output logic [N_CH*EVTNO_W-1:0]     r_expevtno,
    output logic [N_CH*SPILLNO_W-1:0]   r_spillno
);

    // One independent checker per ADC link.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        header_checker_ch #(
            .EVTNO_W   (EVTNO_W),
            .SPILLNO_W (SPILLNO_W),
            .ERRCNT_W  (ERRCNT_W),
            .EVT_START (EVT_START)
        ) u_ch (
            .clk         (clk),
            .live_rising (live_rising),
            .exp_spillno (exp_spillno),
            .get_package (get_package[c]),
            .pkg_evtno   (pkg_evtno[c*EVTNO_W +: EVTNO_W]),
            .pkg_spillno (pkg_spillno[c*SPILLNO_W +: SPILLNO_W]),
            .evtno_err   (evtno_err[c]),
            .spillno_err (spillno_err[c]),
            .err_sticky  (err_sticky[c]),
            .in_counter  (in_counter[c*IN_CNT_W +: IN_CNT_W]),
            .err_count   (err_count[c*ERRCNT_W +: ERRCNT_W]),
            .r_evtno     (r_evtno[c*EVTNO_W +: EVTNO_W]),
            .r_expevtno  (r_expevtno[c*EVTNO_W +: EVTNO_W]),
            .r_spillno   (r_spillno[c*SPILLNO_W +: SPILLNO_W])
        );
    end

    // Global error summary, combinational so it tracks err_sticky directly.
    assign any_err = |err_sticky;

endmodule : header_checker_mc

// File: tb/tb_header_checker_mc.sv
// Self-checking bench for header_checker_mc: directed scenarios plus
// randomized traffic against a behavioural per-channel model.
module tb_header_checker_mc;

    localparam int unsigned N_CH      = 4;
    localparam int unsigned EVTNO_W   = 16;
    localparam int unsigned SPILLNO_W = 10;
    localparam int unsigned ERRCNT_W  = 4;
    localparam int unsigned EVT_START = 1;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned EVT_M     = 1 << EVTNO_W;
    localparam int unsigned SPILL_M   = 1 << SPILLNO_W;
    localparam int unsigned CNT_M     = 1 << CNT_W;
    localparam int unsigned ERR_MAX   = (1 << ERRCNT_W) - 1;
`ifdef HDR_CHK_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    logic                        clk;
    logic                        live_rising;
    logic [SPILLNO_W-1:0]        exp_spillno;
    logic [N_CH-1:0]             get_package;
    logic [N_CH*EVTNO_W-1:0]     pkg_evtno;
    logic [N_CH*SPILLNO_W-1:0]   pkg_spillno;
    logic [N_CH-1:0]             evtno_err;
    logic [N_CH-1:0]             spillno_err;
    logic [N_CH-1:0]             err_sticky;
    logic                        any_err;
    logic [N_CH*CNT_W-1:0]       in_counter;
    logic [N_CH*ERRCNT_W-1:0]    err_count;
    logic [N_CH*EVTNO_W-1:0]     r_evtno;
    logic [N_CH*EVTNO_W-1:0]     r_expevtno;
    logic [N_CH*SPILLNO_W-1:0]   r_spillno;

    header_checker_mc #(
        .N_CH      (N_CH),
        .EVTNO_W   (EVTNO_W),
        .SPILLNO_W (SPILLNO_W),
        .ERRCNT_W  (ERRCNT_W),
        .EVT_START (EVT_START)
    ) dut (
        .clk         (clk),
        .live_rising (live_rising),
        .exp_spillno (exp_spillno),
        .get_package (get_package),
        .pkg_evtno   (pkg_evtno),
        .pkg_spillno (pkg_spillno),
        .evtno_err   (evtno_err),
        .spillno_err (spillno_err),
        .err_sticky  (err_sticky),
        .any_err     (any_err),
        .in_counter  (in_counter),
        .err_count   (err_count),
        .r_evtno     (r_evtno),
        .r_expevtno  (r_expevtno),
        .r_spillno   (r_spillno)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus values for the next step.
    int unsigned drv_evt [N_CH];
    int unsigned drv_sp  [N_CH];
    int unsigned drv_exp_sp;

    // Reference model state.
    int unsigned m_exp   [N_CH];
    int unsigned m_in    [N_CH];
    int unsigned m_errc  [N_CH];
    bit          m_eerr  [N_CH];
    bit          m_serr  [N_CH];
    bit          m_stick [N_CH];
    bit          m_lock_e[N_CH];
    bit          m_lock_s[N_CH];
    int unsigned m_revt  [N_CH];
    int unsigned m_rexp  [N_CH];
    int unsigned m_rsp   [N_CH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_exp[c] = EVT_START % EVT_M;
            m_in[c] = 0; m_errc[c] = 0;
            m_eerr[c] = 0; m_serr[c] = 0; m_stick[c] = 0;
            m_lock_e[c] = 0; m_lock_s[c] = 0;
            m_revt[c] = 0; m_rexp[c] = 0; m_rsp[c] = 0;
        end
    endfunction

    // A package is checked against the running expectation, then the expectation advances.
    function automatic void model_package(int c);
        bit bad_e, bad_s;
        bad_e = (drv_evt[c] != m_exp[c]);
        bad_s = (drv_sp[c] != drv_exp_sp);
        m_eerr[c] = bad_e;
        m_serr[c] = bad_s;
        m_in[c]   = (m_in[c] + 1) % CNT_M;
        if ((bad_e || bad_s) && m_errc[c] < ERR_MAX) m_errc[c]++;
        if (bad_e || bad_s) m_stick[c] = 1;
        if (bad_e && !m_lock_e[c]) begin
            m_lock_e[c] = 1; m_revt[c] = drv_evt[c]; m_rexp[c] = m_exp[c];
        end
        if (bad_s && !m_lock_s[c]) begin
            m_lock_s[c] = 1; m_rsp[c] = drv_sp[c];
        end
        if (RESYNC && bad_e) m_exp[c] = (drv_evt[c] + 1) % EVT_M;
        else                 m_exp[c] = (m_exp[c] + 1) % EVT_M;
    endfunction

    task automatic check_all();
        bit any_m;
        any_m = 0;
        for (int c = 0; c < N_CH; c++) begin
            check($sformatf("evtno_err[%0d]", c),   64'(evtno_err[c]),   64'(m_eerr[c]));
            check($sformatf("spillno_err[%0d]", c), 64'(spillno_err[c]), 64'(m_serr[c]));
            check($sformatf("err_sticky[%0d]", c),  64'(err_sticky[c]),  64'(m_stick[c]));
            check($sformatf("in_counter[%0d]", c),  64'(in_counter[c*CNT_W +: CNT_W]), 64'(m_in[c]));
            check($sformatf("err_count[%0d]", c),   64'(err_count[c*ERRCNT_W +: ERRCNT_W]), 64'(m_errc[c]));
            check($sformatf("r_evtno[%0d]", c),     64'(r_evtno[c*EVTNO_W +: EVTNO_W]), 64'(m_revt[c]));
            check($sformatf("r_expevtno[%0d]", c),  64'(r_expevtno[c*EVTNO_W +: EVTNO_W]), 64'(m_rexp[c]));
            check($sformatf("r_spillno[%0d]", c),   64'(r_spillno[c*SPILLNO_W +: SPILLNO_W]), 64'(m_rsp[c]));
            any_m |= m_stick[c];
        end
        check("any_err", 64'(any_err), 64'(any_m));
    endtask

    // One clock: drive at the falling edge, update model at the rising edge, check just after.
    task automatic step(input bit rst, input logic [N_CH-1:0] stb, input bit chk);
        @(negedge clk);
        live_rising = rst;
        get_package = stb;
        exp_spillno = SPILLNO_W'(drv_exp_sp);
        for (int c = 0; c < N_CH; c++) begin
            pkg_evtno[c*EVTNO_W +: EVTNO_W]       = EVTNO_W'(drv_evt[c]);
            pkg_spillno[c*SPILLNO_W +: SPILLNO_W] = SPILLNO_W'(drv_sp[c]);
        end
        @(posedge clk);
        if (rst) model_reset();
        else for (int c = 0; c < N_CH; c++) if (stb[c]) model_package(c);
        #1;
        live_rising = 1'b0;
        get_package = '0;
        if (chk) check_all();
    endtask

    function automatic void all_good();
        for (int c = 0; c < N_CH; c++) begin
            drv_evt[c] = m_exp[c];
            drv_sp[c]  = drv_exp_sp;
        end
    endfunction

    initial begin
        int unsigned seq[4];
        live_rising = 1'b0;
        get_package = '0;
        pkg_evtno   = '0;
        pkg_spillno = '0;
        exp_spillno = '0;
        drv_exp_sp  = 0;
        model_reset();
        all_good();

        // Reset state
        step(1'b1, '0, 1'b1);
        check("rst_any_err", 64'(any_err), 64'd0);
        check("rst_in_counter", 64'(in_counter), 64'd0);

        // Nominal: five good packages on ch0
        drv_exp_sp = 7;
        for (int i = 1; i <= 5; i++) begin
            all_good(); drv_evt[0] = i; drv_sp[0] = 7;
            step(1'b0, 4'b0001, 1'b1);
        end
        check("nom_in_counter", 64'(in_counter[15:0]), 64'd5);
        check("nom_err_count", 64'(err_count[3:0]), 64'd0);
        check("nom_any_err", 64'(any_err), 64'd0);

        // Dropped package on ch1
        seq = '{1, 2, 4, 5};
        for (int i = 0; i < 4; i++) begin
            all_good(); drv_evt[1] = seq[i];
            step(1'b0, 4'b0010, 1'b1);
        end
        check("drop_err_count", 64'(err_count[7:4]), RESYNC ? 64'd1 : 64'd2);
        check("drop_last_evtno_err", 64'(evtno_err[1]), RESYNC ? 64'd0 : 64'd1);
        check("drop_r_evtno", 64'(r_evtno[31:16]), 64'd4);
        check("drop_r_expevtno", 64'(r_expevtno[31:16]), 64'd3);

        // Idle cycle: flags hold
        step(1'b0, '0, 1'b1);

        // Spill mismatch on ch2
        drv_exp_sp = 10;
        all_good(); drv_sp[2] = 9;
        step(1'b0, 4'b0100, 1'b1);
        all_good(); drv_sp[2] = 11;
        step(1'b0, 4'b0100, 1'b1);
        check("spill_err", 64'(spillno_err[2]), 64'd1);
        check("spill_r_spillno", 64'(r_spillno[29:20]), 64'd9);
        check("spill_err_count", 64'(err_count[11:8]), 64'd2);

        // Simultaneous strobes, ch3 mismatched
        step(1'b1, '0, 1'b1);
        all_good(); drv_evt[3] = 5;
        step(1'b0, 4'b1111, 1'b1);
        check("sim_evtno_err", 64'(evtno_err), 64'b1000);
        check("sim_err_sticky", 64'(err_sticky), 64'b1000);
        check("sim_any_err", 64'(any_err), 64'd1);

        // Saturation on ch1
        for (int i = 0; i < 20; i++) begin
            all_good(); drv_evt[1] = (m_exp[1] + 7) % EVT_M;
            step(1'b0, 4'b0010, 1'b1);
        end
        check("sat_err_count", 64'(err_count[7:4]), 64'd15);

        // Reset colliding with a strobe on ch0 after an error
        all_good(); drv_evt[0] = (m_exp[0] + 3) % EVT_M;
        step(1'b0, 4'b0001, 1'b1);
        all_good(); drv_evt[0] = 1;
        step(1'b1, 4'b0001, 1'b1);
        check("coll_in_counter", 64'(in_counter[15:0]), 64'd0);
        check("coll_any_err", 64'(any_err), 64'd0);
        check("coll_err_count", 64'(err_count), 64'd0);
        all_good(); drv_evt[0] = 1;
        step(1'b0, 4'b0001, 1'b1);
        check("coll_next_ok", 64'(evtno_err[0]), 64'd0);

        // Event number and package counter wrap on ch0
        step(1'b1, '0, 1'b1);
        for (int i = 1; i < EVT_M; i++) begin
            all_good(); drv_evt[0] = i;
            step(1'b0, 4'b0001, 1'b0);
        end
        check_all();
        check("wrap_in_counter", 64'(in_counter[15:0]), 64'd65535);
        all_good(); drv_evt[0] = 0;
        step(1'b0, 4'b0001, 1'b1);
        check("wrap_evt0_ok", 64'(evtno_err[0]), 64'd0);
        check("wrap_in_counter0", 64'(in_counter[15:0]), 64'd0);

        // Randomized traffic
        step(1'b1, '0, 1'b1);
        for (int n = 0; n < 3000; n++) begin
            bit rst;
            logic [N_CH-1:0] stb;
            if ($urandom_range(0, 99) == 0) drv_exp_sp = $urandom_range(0, SPILL_M - 1);
            rst = ($urandom_range(0, 299) == 0);
            stb = N_CH'($urandom);
            for (int c = 0; c < N_CH; c++) begin
                case ($urandom_range(0, 9))
                    0:       drv_evt[c] = $urandom_range(0, EVT_M - 1);
                    1:       drv_evt[c] = (m_exp[c] + 1) % EVT_M;
                    2:       drv_evt[c] = (m_exp[c] + EVT_M - 1) % EVT_M;
                    default: drv_evt[c] = m_exp[c];
                endcase
                drv_sp[c] = ($urandom_range(0, 11) == 0) ? $urandom_range(0, SPILL_M - 1) : drv_exp_sp;
            end
            step(rst, stb, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_header_checker_mc

// File: doc/header_checker_mc.md
# header_checker_mc

Multi-channel, parametrised header consistency checker for the OFC1 receive path. Each of N_CH ADC links delivers package headers carrying an event number and a spill number. Per channel, the block checks them against a running expected event number and the global expected spill number. It keeps per-channel error flags, saturating error counters, first-error capture registers and package counters, plus a global error summary for the register map.

## Interface
Parameters:
- N_CH, 4, number of ADC input channels (1..16)
- EVTNO_W, 16, event number width
- SPILLNO_W, 10, spill number width
- ERRCNT_W, 8, per-channel error counter width (saturating)
- EVT_START, 1, expected event number of the first package after reset

Ports:
- clk  in  1  system clock; all logic on rising edge
- live_rising  in  1  synchronous active-high reset (run start pulse)
- exp_spillno  in  SPILLNO_W  expected spill number, common to all channels
- get_package  in  N_CH  per-channel header strobe, 1-cycle pulse
- pkg_evtno  in  N_CH*EVTNO_W  channel c at bits [c*EVTNO_W +: EVTNO_W]
- pkg_spillno  in  N_CH*SPILLNO_W  channel c at bits [c*SPILLNO_W +: SPILLNO_W]
- evtno_err  out  N_CH  result of the last check, event number mismatch
- spillno_err  out  N_CH  result of the last check, spill number mismatch
- err_sticky  out  N_CH  set on any mismatch; cleared only by reset
- any_err  out  1  OR of err_sticky
- in_counter  out  N_CH*16  packages received per channel
- err_count  out  N_CH*ERRCNT_W  packages with any mismatch, per channel
- r_evtno, r_expevtno  out  N_CH*EVTNO_W  received and expected event number at the first evtno error
- r_spillno  out  N_CH*SPILLNO_W  received spill number at the first spillno error

## Operation
- Channels are fully independent. All strobes may assert in the same cycle.
- On get_package[c]:
  - evtno_err[c] = (pkg_evtno != exp_evtno[c]).
  - spillno_err[c] = (pkg_spillno != exp_spillno).
  - in_counter[c] += 1.
- exp_evtno[c] advances by 1 per package, modulo 2^EVTNO_W; 2^EVTNO_W-1 wraps to 0.
- in_counter wraps at 2^16.
- err_count[c] increments once per package with either mismatch. It saturates at 2^ERRCNT_W-1.
- First-error capture:
  - On the first evtno mismatch after reset, r_evtno and r_expevtno load the offending pkg_evtno and exp_evtno.
  - The capture is taken in the same cycle as the flag update, so the values belong to the mismatching package.
  - A lock bit then holds them until reset. The spill path has its own lock bit.
- Without a new strobe, evtno_err and spillno_err hold their last value.
- Reset values: all outputs 0, exp_evtno = EVT_START, lock bits cleared.
- live_rising in the same cycle as get_package: reset wins and the package is discarded.

## Timing
- Check latency is 1 cycle. Flags, counters, capture registers and err_sticky update on the edge after get_package is sampled.
- any_err lags err_sticky by 0 cycles (combinational OR).
- Back-to-back strobes on a channel every cycle are supported; there is no throughput limit.
- exp_spillno is sampled in the strobe cycle.

## Configuration
- HDR_CHK_RESYNC_EN defined:
  - On an evtno mismatch, exp_evtno[c] loads pkg_evtno+1 (modulo).
  - A single dropped or duplicated package therefore yields exactly one error rather than a permanent offset.
- HDR_CHK_RESYNC_EN undefined: exp_evtno[c] always increments by 1. This is the legacy behaviour.
- In both builds:
  - Capture registers hold the first error only.
  - Spill mismatches never alter exp_evtno.

## Structure
- Package hdr_chk_pkg holds the default widths (EVTNO_W, SPILLNO_W, ERRCNT_W), EVT_START, and the per-channel slice helper constants.
- Sub-module header_checker_ch implements one channel: expected counter, compare, locks, error counter and capture. It is instantiated N_CH times in a generate loop.
- The top level does only slicing, concatenation and the any_err reduction.

## Test plan
- Nominal: reset, then 5 packages on ch0 with evtno 1..5 and spill = exp_spillno = 7 -> flags 0, in_counter=5, err_count=0, any_err=0.
- Dropped package: ch1 receives evtno 1,2,4,5:
  - Without RESYNC -> evtno_err=1 on 4 and 5, err_count=2, r_evtno=4, r_expevtno=3.
  - With RESYNC -> error on 4 only, err_count=1, and 5 passes.
- Spill mismatch: exp_spillno=10, ch2 gets spill 9 then 11 -> spillno_err=1 both times, r_spillno=9 (locked), err_count=2.
- Wrap and saturation:
  - Preload by sending 65535 good packages -> the next expected evtno is 0, and evtno 0 passes.
  - With ERRCNT_W=4, 20 bad packages -> err_count=15.
- Simultaneous: all 4 channels strobe in the same cycle, ch3 mismatched -> only evtno_err[3]=1, err_sticky=4'b1000, any_err=1.
- Reset collision: live_rising together with get_package on ch0 after an error -> all outputs 0, in_counter[0]=0, the next evtno 1 passes.
